axi4_bch_drop_injector: RTL and testbench
=========================================

# axi4_bch_drop_injector

Write-response (B) channel injector for the RAB slave port: generates error responses for write transactions the RAB has dropped, and merges them with genuine B responses from the master side. It extends the single-drop B sender with a parametrised queue of outstanding drops, per-burst WLAST tracking, selectable error code, fair arbitration and a locked-until-handshake output. It sits between the RAB's B-channel master port (m_) and the upstream slave port (s_).

## Interface
- C_AXI_ID_WIDTH, 10, transaction ID width
- C_AXI_USER_WIDTH, 4, B user width
- C_DROP_DEPTH, 4, outstanding dropped-transaction entries; power of two, ≥2
- C_DROP_RESP, 2'b10, BRESP for injected responses (SLVERR; 2'b11 = DECERR)
- C_FAIR, 1, 1 = alternate between injected and forwarded responses when both pending; 0 = forwarded always wins
- axi4_aclk  in  1  clock
- axi4_arst  in  1  reset; one clock, asynchronous, active-high
- trans_drop  in  1  pulse: AW of a dropped transaction accepted this cycle
- trans_id  in  C_AXI_ID_WIDTH  ID of that transaction
- trans_ready  out  1  queue not full
- w_drop  in  1  current W beat belongs to a dropped burst
- s_axi4_wvalid / s_axi4_wready / s_axi4_wlast  in  1 each  slave W handshake, observed only
- s_axi4_bid / bresp / buser / bvalid  out  ID / 2 / USER / 1  upstream B
- s_axi4_bready  in  1
- m_axi4_bid / bresp / buser / bvalid  in  ID / 2 / USER / 1  downstream B
- m_axi4_bready  out  1
- drop_pending  out  $clog2(C_DROP_DEPTH)+1  queued entries
- drop_overflow  out  1  sticky: trans_drop while full

## Operation
- Queue: trans_drop && trans_ready pushes trans_id. trans_drop while full: entry discarded, drop_overflow set (cleared only by reset).
- WLAST counter wl_cnt (0..C_DROP_DEPTH): +1 on s_axi4_wvalid && s_axi4_wready && s_axi4_wlast && w_drop; −1 on injected-response handshake; both same cycle → unchanged. Saturates at C_DROP_DEPTH (never exceeds queue).
- Inject eligible: queue non-empty && wl_cnt > 0.
- Owner: INJ or FWD. When not locked, owner chosen combinationally: only one requester → it; both → C_FAIR=0: FWD; C_FAIR=1: opposite of last served (reset: last=INJ, so FWD first).
- Lock: s_axi4_bvalid && !s_axi4_bready registers owner; held until handshake. Prevents BID/BRESP changing while valid (AXI stability).
- FWD: s_ = m_ fields, s_axi4_bvalid = m_axi4_bvalid, m_axi4_bready = s_axi4_bready.
- INJ: s_axi4_bid = queue head, bresp = C_DROP_RESP, buser = 0, bvalid = 1, m_axi4_bready = 0. Handshake pops queue, decrements wl_cnt.

## Timing
- Reset: queue empty, wl_cnt 0, lock clear, drop_overflow 0, drop_pending 0, trans_ready 1, s_axi4_bvalid 0 unless m_axi4_bvalid (pure pass-through), m_axi4_bready = s_axi4_bready.
- Forward path: zero latency, combinational.
- Push → head visible next cycle; WLAST handshake → wl_cnt visible next cycle; earliest injected bvalid is cycle after the later of the two.
- Pop and push same cycle at full: allowed, trans_ready reflects pre-pop state (stays 0 that cycle).
- Back-to-back injections: one per cycle while eligible and s_axi4_bready=1.
- Reset mid-injection: bvalid drops asynchronously; queued IDs lost.

## Structure
- Package axi_rab_pkg: RESP_OKAY/EXOKAY/SLVERR/DECERR constants, owner enum {OWN_FWD, OWN_INJ}.
- Sub-module axi4_bch_drop_fifo: DEPTH×ID_WIDTH circular buffer, wrap-around pointers with extra MSB, count output.

## Test plan
- Single drop: trans_drop id=0x05, then WLAST with w_drop → next cycle s_bvalid=1, bid=0x05, bresp=2'b10, buser=0; m_bready=0.
- Order: drops 0x01,0x02,0x03, WLASTs for first two only → exactly two injections 0x01,0x02; 0x03 held until third WLAST.
- Contention, C_FAIR=1, m_bvalid held with id 0x3FF and 3 eligible drops, bready=1 → FWD,INJ,FWD,INJ,FWD,INJ order; C_FAIR=0 → all forwarded first.
- Lock: INJ asserted with bready=0 for 5 cycles while m_bvalid rises → bid stays constant, m_bready=0, forwarded after handshake.
- Overflow: 5 drops with depth 4 → trans_ready=0 after 4th, drop_overflow=1, drop_pending=4; only 4 injections.
- Reset asserted while injecting → s_bvalid=0 same cycle, drop_pending=0, drop_overflow=0.

Source files
------------

// File: rtl/axi_rab_pkg.sv
// Shared RAB definitions: AXI response codes and the B-channel owner select.
package axi_rab_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic {
        OWN_FWD = 1'b0,
        OWN_INJ = 1'b1
    } owner_e;

endpackage

// File: rtl/axi4_bch_drop_fifo.sv
// Circular buffer of dropped-transaction IDs; pointers carry an extra MSB so full/empty need no flag.
module axi4_bch_drop_fifo #(
    parameter int DEPTH = 4,
    parameter int ID_W  = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [ID_W-1:0]          i_din,
    input  logic                     i_pop,
    output logic [ID_W-1:0]          o_head,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]     r_wptr;
    logic [AW:0]     r_rptr;
    logic [ID_W-1:0] r_mem [DEPTH];
    logic            w_push;
    logic            w_pop;

    // Full is judged on the pre-pop state, so a push at full is refused even if a pop coincides.
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_count = r_wptr - r_rptr;
    assign o_full  = (o_count == (AW+1)'(DEPTH));
    assign o_empty = (r_wptr == r_rptr);
    assign o_head  = r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + (AW+1)'(1);
            if (w_pop)  r_rptr <= r_rptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr[AW-1:0]] <= i_din;
    end

endmodule

// File: rtl/axi4_bch_drop_injector.sv
// B-channel injector: answers dropped writes with error responses once their WLAST has been
// seen, and merges those with genuine master-side B responses under a lock-until-handshake arbiter.
module axi4_bch_drop_injector
    import axi_rab_pkg::*;
#(
    parameter int         C_AXI_ID_WIDTH   = 10,
    parameter int         C_AXI_USER_WIDTH = 4,
    parameter int         C_DROP_DEPTH     = 4,
    parameter logic [1:0] C_DROP_RESP      = RESP_SLVERR,
    parameter int         C_FAIR           = 1
) (
    input  logic                            axi4_aclk,
    input  logic                            axi4_arst,
    input  logic                            trans_drop,
    input  logic [C_AXI_ID_WIDTH-1:0]       trans_id,
    output logic                            trans_ready,
    input  logic                            w_drop,
    input  logic                            s_axi4_wvalid,
    input  logic                            s_axi4_wready,
    input  logic                            s_axi4_wlast,
    output logic [C_AXI_ID_WIDTH-1:0]       s_axi4_bid,
    output logic [1:0]                      s_axi4_bresp,
    output logic [C_AXI_USER_WIDTH-1:0]     s_axi4_buser,
    output logic                            s_axi4_bvalid,
    input  logic                            s_axi4_bready,
    input  logic [C_AXI_ID_WIDTH-1:0]       m_axi4_bid,
    input  logic [1:0]                      m_axi4_bresp,
    input  logic [C_AXI_USER_WIDTH-1:0]     m_axi4_buser,
    input  logic                            m_axi4_bvalid,
    output logic                            m_axi4_bready,
    output logic [$clog2(C_DROP_DEPTH):0]   drop_pending,
    output logic                            drop_overflow
);
    localparam int CW = $clog2(C_DROP_DEPTH) + 1;

    logic [C_AXI_ID_WIDTH-1:0] w_head;
    logic [CW-1:0]             w_count;
    logic                      w_full;
    logic                      w_empty;
    logic                      w_inj_req;
    logic                      w_inj_hs;
    logic                      w_wlast_hs;
    owner_e                    w_owner;
    logic [CW-1:0]             r_wl_cnt;
    logic                      r_overflow;
    logic                      r_locked;
    owner_e                    r_lock_owner;
    owner_e                    r_last;

    axi4_bch_drop_fifo #(
        .DEPTH (C_DROP_DEPTH),
        .ID_W  (C_AXI_ID_WIDTH)
    ) u_fifo (
        .clk     (axi4_aclk),
        .rst     (axi4_arst),
        .i_push  (trans_drop),
        .i_din   (trans_id),
        .i_pop   (w_inj_hs),
        .o_head  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign trans_ready   = !w_full;
    assign drop_pending  = w_count;
    assign drop_overflow = r_overflow;
    assign w_wlast_hs    = s_axi4_wvalid && s_axi4_wready && s_axi4_wlast && w_drop;
    assign w_inj_req     = !w_empty && (r_wl_cnt != '0);
    assign w_inj_hs      = (w_owner == OWN_INJ) && s_axi4_bready;

    // A locked owner keeps the output stable; otherwise arbitrate between the two requesters.
    always_comb begin
        w_owner = OWN_FWD;
        if (r_locked) begin
            w_owner = r_lock_owner;
        end else if (w_inj_req && m_axi4_bvalid) begin
            w_owner = (C_FAIR != 0 && r_last == OWN_FWD) ? OWN_INJ : OWN_FWD;
        end else if (w_inj_req) begin
            w_owner = OWN_INJ;
        end
    end

    always_comb begin
        s_axi4_bid    = m_axi4_bid;
        s_axi4_bresp  = m_axi4_bresp;
        s_axi4_buser  = m_axi4_buser;
        s_axi4_bvalid = m_axi4_bvalid;
        m_axi4_bready = s_axi4_bready;
        if (w_owner == OWN_INJ) begin
            s_axi4_bid    = w_head;
            s_axi4_bresp  = C_DROP_RESP;
            s_axi4_buser  = '0;
            s_axi4_bvalid = 1'b1;
            m_axi4_bready = 1'b0;
        end
    end

    always_ff @(posedge axi4_aclk or posedge axi4_arst) begin
        if (axi4_arst) begin
            r_wl_cnt     <= '0;
            r_overflow   <= 1'b0;
            r_locked     <= 1'b0;
            r_lock_owner <= OWN_FWD;
            r_last       <= OWN_INJ;
        end else begin
            if (trans_drop && w_full) r_overflow <= 1'b1;
            // WLAST count saturates at the queue depth; a coincident WLAST and injection cancel.
            if (w_wlast_hs && !w_inj_hs && r_wl_cnt != CW'(C_DROP_DEPTH))
                r_wl_cnt <= r_wl_cnt + CW'(1);
            else if (!w_wlast_hs && w_inj_hs)
                r_wl_cnt <= r_wl_cnt - CW'(1);
            r_locked     <= s_axi4_bvalid && !s_axi4_bready;
            r_lock_owner <= w_owner;
            if (s_axi4_bvalid && s_axi4_bready) r_last <= w_owner;
        end
    end

endmodule

// File: tb/tb_axi4_bch_drop_injector.sv
// Randomized and directed bench for axi4_bch_drop_injector against a queue-based reference model.
module tb_axi4_bch_drop_injector;
    localparam int IDW   = 10;
    localparam int UW    = 4;
    localparam int DEPTH = 4;
    localparam int FAIR  = 1;

    logic           axi4_aclk = 1'b0;
    logic           axi4_arst;
    logic           trans_drop;
    logic [IDW-1:0] trans_id;
    logic           trans_ready;
    logic           w_drop;
    logic           s_axi4_wvalid, s_axi4_wready, s_axi4_wlast;
    logic [IDW-1:0] s_axi4_bid;
    logic [1:0]     s_axi4_bresp;
    logic [UW-1:0]  s_axi4_buser;
    logic           s_axi4_bvalid;
    logic           s_axi4_bready;
    logic [IDW-1:0] m_axi4_bid;
    logic [1:0]     m_axi4_bresp;
    logic [UW-1:0]  m_axi4_buser;
    logic           m_axi4_bvalid;
    logic           m_axi4_bready;
    logic [2:0]     drop_pending;
    logic           drop_overflow;

    axi4_bch_drop_injector #(
        .C_AXI_ID_WIDTH   (IDW),
        .C_AXI_USER_WIDTH (UW),
        .C_DROP_DEPTH     (DEPTH),
        .C_DROP_RESP      (2'b10),
        .C_FAIR           (FAIR)
    ) dut (
        .axi4_aclk     (axi4_aclk),
        .axi4_arst     (axi4_arst),
        .trans_drop    (trans_drop),
        .trans_id      (trans_id),
        .trans_ready   (trans_ready),
        .w_drop        (w_drop),
        .s_axi4_wvalid (s_axi4_wvalid),
        .s_axi4_wready (s_axi4_wready),
        .s_axi4_wlast  (s_axi4_wlast),
        .s_axi4_bid    (s_axi4_bid),
        .s_axi4_bresp  (s_axi4_bresp),
        .s_axi4_buser  (s_axi4_buser),
        .s_axi4_bvalid (s_axi4_bvalid),
        .s_axi4_bready (s_axi4_bready),
        .m_axi4_bid    (m_axi4_bid),
        .m_axi4_bresp  (m_axi4_bresp),
        .m_axi4_buser  (m_axi4_buser),
        .m_axi4_bvalid (m_axi4_bvalid),
        .m_axi4_bready (m_axi4_bready),
        .drop_pending  (drop_pending),
        .drop_overflow (drop_overflow)
    );

    always #5 axi4_aclk = ~axi4_aclk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: pending IDs, count of completed dropped bursts, sticky overflow,
    // who was served last, and whether a response is being held awaiting bready.
    logic [IDW-1:0] mq[$];
    int             wl;
    bit             ovf;
    bit             last_inj;
    bit             held;
    bit             held_inj;

    bit             kind_log[$];
    logic [IDW-1:0] id_log[$];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        wl       = 0;
        ovf      = 1'b0;
        last_inj = 1'b1;
        held     = 1'b0;
        held_inj = 1'b0;
    endtask

    task automatic drive_idle();
        trans_drop    = 1'b0;
        trans_id      = '0;
        w_drop        = 1'b0;
        s_axi4_wvalid = 1'b0;
        s_axi4_wready = 1'b0;
        s_axi4_wlast  = 1'b0;
        s_axi4_bready = 1'b0;
        m_axi4_bvalid = 1'b0;
        m_axi4_bid    = '0;
        m_axi4_bresp  = 2'b00;
        m_axi4_buser  = '0;
    endtask

    task automatic do_reset();
        axi4_arst = 1'b1;
        drive_idle();
        model_reset();
        @(posedge axi4_aclk);
        #1;
        axi4_arst = 1'b0;
    endtask

    // One clock cycle: drive inputs, check every output against the model, advance the model.
    task automatic step(input bit drop, input logic [IDW-1:0] id, input bit wbeat, input bit wlast,
                        input bit wd, input bit sbr, input bit mv, input logic [IDW-1:0] mid,
                        input logic [UW-1:0] muser);
        bit inj_ok, own_inj, e_bvalid, hs, inc, dec;
        logic [IDW-1:0] e_bid;
        logic [1:0] e_resp;
        logic [UW-1:0] e_user;
        @(posedge axi4_aclk);
        #1;
        trans_drop    = drop;
        trans_id      = id;
        s_axi4_wvalid = wbeat;
        s_axi4_wready = wbeat;
        s_axi4_wlast  = wlast;
        w_drop        = wd;
        s_axi4_bready = sbr;
        m_axi4_bvalid = mv;
        m_axi4_bid    = mid;
        m_axi4_bresp  = mid[1:0];
        m_axi4_buser  = muser;
        #1;
        inj_ok = (mq.size() > 0) && (wl > 0);
        if (held)               own_inj = held_inj;
        else if (inj_ok && mv)  own_inj = (FAIR != 0) ? !last_inj : 1'b0;
        else                    own_inj = inj_ok;
        e_bvalid = own_inj ? 1'b1 : mv;
        e_bid    = own_inj ? mq[0] : mid;
        e_resp   = own_inj ? 2'b10 : mid[1:0];
        e_user   = own_inj ? '0 : muser;
        chk("bvalid", 32'(s_axi4_bvalid), 32'(e_bvalid));
        chk("bid", 32'(s_axi4_bid), 32'(e_bid));
        chk("bresp", 32'(s_axi4_bresp), 32'(e_resp));
        chk("buser", 32'(s_axi4_buser), 32'(e_user));
        chk("m_bready", 32'(m_axi4_bready), 32'(own_inj ? 1'b0 : sbr));
        chk("trans_ready", 32'(trans_ready), 32'(mq.size() < DEPTH));
        chk("drop_pending", 32'(drop_pending), 32'(mq.size()));
        chk("drop_overflow", 32'(drop_overflow), 32'(ovf));
        if (s_axi4_bvalid && s_axi4_bready) begin
            kind_log.push_back(!m_axi4_bready);
            id_log.push_back(s_axi4_bid);
        end
        hs  = e_bvalid && sbr;
        inc = wbeat && wlast && wd;
        dec = hs && own_inj;
        if (drop && mq.size() >= DEPTH) ovf = 1'b1;
        if (drop && mq.size() < DEPTH) begin
            if (dec) void'(mq.pop_front());
            mq.push_back(id);
        end else if (dec) begin
            void'(mq.pop_front());
        end
        if (inc && !dec && wl < DEPTH) wl++;
        else if (dec && !inc)          wl--;
        if (hs) last_inj = own_inj;
        held     = e_bvalid && !sbr;
        held_inj = own_inj;
    endtask

    task automatic st(input bit drop, input logic [IDW-1:0] id, input bit wl_beat, input bit sbr,
                      input bit mv, input logic [IDW-1:0] mid);
        step(drop, id, wl_beat, wl_beat, wl_beat, sbr, mv, mid, 4'h3);
    endtask

    initial begin
        bit             mv, mhold;
        logic [IDW-1:0] mid;
        logic [UW-1:0]  muser;
        int             ninj;

        do_reset();
        #1;
        chk("rst_bvalid", 32'(s_axi4_bvalid), 32'd0);
        chk("rst_pending", 32'(drop_pending), 32'd0);
        chk("rst_trans_ready", 32'(trans_ready), 32'd1);
        chk("rst_overflow", 32'(drop_overflow), 32'd0);

        // Single drop: response appears only after its WLAST has been registered.
        st(1, 10'h005, 0, 0, 0, '0);
        st(0, '0, 1, 0, 0, '0);
        chk("single_not_early", 32'(s_axi4_bvalid), 32'd0);
        st(0, '0, 0, 0, 0, '0);
        chk("single_bvalid", 32'(s_axi4_bvalid), 32'd1);
        chk("single_bid", 32'(s_axi4_bid), 32'h005);
        chk("single_bresp", 32'(s_axi4_bresp), 32'd2);
        chk("single_mbready", 32'(m_axi4_bready), 32'd0);

        // Ordering: only bursts with a completed WLAST get answered.
        do_reset();
        kind_log.delete(); id_log.delete();
        st(1, 10'h001, 0, 1, 0, '0);
        st(1, 10'h002, 0, 1, 0, '0);
        st(1, 10'h003, 0, 1, 0, '0);
        st(0, '0, 1, 1, 0, '0);
        st(0, '0, 1, 1, 0, '0);
        for (int i = 0; i < 4; i++) st(0, '0, 0, 1, 0, '0);
        chk("order_count2", 32'(id_log.size()), 32'd2);
        if (id_log.size() >= 2) begin
            chk("order_id0", 32'(id_log[0]), 32'h001);
            chk("order_id1", 32'(id_log[1]), 32'h002);
        end
        st(0, '0, 1, 1, 0, '0);
        st(0, '0, 0, 1, 0, '0);
        st(0, '0, 0, 1, 0, '0);
        chk("order_count3", 32'(id_log.size()), 32'd3);
        if (id_log.size() >= 3) chk("order_id2", 32'(id_log[2]), 32'h003);

        // Fair contention: forwarded response goes first, then strict alternation.
        do_reset();
        st(1, 10'h011, 1, 0, 1, 10'h3FF);
        st(1, 10'h012, 1, 0, 1, 10'h3FF);
        st(1, 10'h013, 1, 0, 1, 10'h3FF);
        kind_log.delete(); id_log.delete();
        for (int i = 0; i < 6; i++) st(0, '0, 0, 1, 1, 10'h3FF);
        chk("fair_count", 32'(kind_log.size()), 32'd6);
        for (int i = 0; i < 6 && i < kind_log.size(); i++)
            chk($sformatf("fair_kind%0d", i), 32'(kind_log[i]), 32'(i % 2));

        // Lock: a stalled injected response must not change while the master becomes valid.
        do_reset();
        st(1, 10'h02A, 1, 0, 0, '0);
        for (int i = 0; i < 5; i++) begin
            st(0, '0, 0, 0, (i >= 1), 10'h155);
            chk("lock_bid", 32'(s_axi4_bid), 32'h02A);
            chk("lock_mbready", 32'(m_axi4_bready), 32'd0);
        end
        kind_log.delete(); id_log.delete();
        st(0, '0, 0, 1, 1, 10'h155);
        st(0, '0, 0, 1, 1, 10'h155);
        chk("lock_hs_count", 32'(kind_log.size()), 32'd2);
        if (kind_log.size() >= 2) begin
            chk("lock_first_inj", 32'(kind_log[0]), 32'd1);
            chk("lock_then_fwd", 32'(kind_log[1]), 32'd0);
            chk("lock_fwd_id", 32'(id_log[1]), 32'h155);
        end

        // Overflow: fifth drop with a full queue is discarded and flagged.
        do_reset();
        for (int i = 0; i < 4; i++) st(1, IDW'(10'h030 + i), 0, 0, 0, '0);
        st(1, 10'h034, 0, 0, 0, '0);
        chk("ovf_trans_ready", 32'(trans_ready), 32'd0);
        st(0, '0, 0, 0, 0, '0);
        chk("ovf_flag", 32'(drop_overflow), 32'd1);
        chk("ovf_pending", 32'(drop_pending), 32'd4);
        kind_log.delete(); id_log.delete();
        for (int i = 0; i < 5; i++) st(0, '0, 1, 1, 0, '0);
        for (int i = 0; i < 4; i++) st(0, '0, 0, 1, 0, '0);
        ninj = 0;
        foreach (kind_log[i]) if (kind_log[i]) ninj++;
        chk("ovf_injections", 32'(ninj), 32'd4);
        if (id_log.size() >= 4) chk("ovf_last_id", 32'(id_log[3]), 32'h033);

        // Reset in the middle of a stalled injection.
        st(1, 10'h03C, 0, 0, 0, '0);
        st(0, '0, 0, 0, 0, '0);
        chk("rstmid_bvalid_before", 32'(s_axi4_bvalid), 32'd1);
        axi4_arst = 1'b1;
        #1;
        chk("rstmid_bvalid", 32'(s_axi4_bvalid), 32'd0);
        chk("rstmid_pending", 32'(drop_pending), 32'd0);
        chk("rstmid_overflow", 32'(drop_overflow), 32'd0);
        do_reset();

        // Randomized traffic; the master side obeys AXI valid/ID stability.
        mhold = 1'b0;
        mv    = 1'b0;
        mid   = '0;
        muser = '0;
        for (int c = 0; c < 1500; c++) begin
            if (!mhold) begin
                mv    = ($urandom_range(0, 2) == 0);
                mid   = IDW'($urandom);
                muser = UW'($urandom);
            end
            step(($urandom_range(0, 3) == 0), IDW'($urandom), $urandom_range(0, 1) == 1,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 3) != 0, mv, mid, muser);
            mhold = m_axi4_bvalid && !m_axi4_bready;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
